// File: rtl/delay_seq_pkg.sv
// Shared types, limits and helpers for the delay_seq_matcher "a ##[MIN:MAX] b" monitor.
package delay_seq_pkg;

    typedef enum logic {
        FIRST_MATCH,
        ALL_MATCH
    } match_mode_e;

    localparam int MAX_DELAY_LIMIT = 63;
    localparam int MAX_CH_LIMIT    = 16;

    // Widest possible window: ages 0..MAX_DELAY_LIMIT.
    localparam int WIN_W = MAX_DELAY_LIMIT + 1;
    localparam int POP_W = $clog2(WIN_W + 1);

    function automatic logic [POP_W-1:0] popcount(input logic [WIN_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIN_W; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/delay_seq_channel.sv
// One channel of the matcher: age-indexed pending/hit vectors, match/expiry
// detection and two saturating event counters.
module delay_seq_channel
    import delay_seq_pkg::*;
#(
    parameter int          MIN_DELAY = 1,
    parameter int          MAX_DELAY = 3,
    parameter match_mode_e MODE      = FIRST_MATCH,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    output logic             match,
    output logic             fail,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int SUM_W = CNT_W + POP_W;
    localparam logic [MAX_DELAY:0] WIN_MASK = {(MAX_DELAY + 1){1'b1}} << MIN_DELAY;

    logic [MAX_DELAY:1] pend, hit;
    logic [MAX_DELAY:1] pend_nxt, hit_nxt;
    logic [MAX_DELAY:0] live, hit_cur, mvec;
    logic [WIN_W-1:0]   mvec_ext;
    logic [POP_W-1:0]   n_match;
    logic [SUM_W-1:0]   match_sum;
    logic [CNT_W-1:0]   match_cnt_nxt;
    logic               expire;

    // NOTE: every variable is assigned before any branch, so no path can infer a latch.
    always_comb begin
        live     = {pend, a};
        hit_cur  = {hit, 1'b0};
        mvec     = live & WIN_MASK & {(MAX_DELAY + 1){b}};
        expire   = live[MAX_DELAY] & ~mvec[MAX_DELAY] & ~hit_cur[MAX_DELAY];
        pend_nxt = live[MAX_DELAY-1:0];
        hit_nxt  = '0;
        if (MODE == FIRST_MATCH) begin
            pend_nxt = live[MAX_DELAY-1:0] & ~mvec[MAX_DELAY-1:0];
        end else begin
            hit_nxt  = hit_cur[MAX_DELAY-1:0] | mvec[MAX_DELAY-1:0];
        end
        mvec_ext                = '0;
        mvec_ext[MAX_DELAY:0]   = mvec;
        n_match                 = popcount(mvec_ext);
        match_sum               = SUM_W'(match_cnt) + SUM_W'(n_match);
        match_cnt_nxt           = (match_sum > SUM_W'({CNT_W{1'b1}})) ? '1
                                                                      : match_sum[CNT_W-1:0];
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            // In-flight attempts are discarded silently: a clear is not an expiry.
            pend      <= '0;
            hit       <= '0;
            match     <= 1'b0;
            fail      <= 1'b0;
            match_cnt <= '0;
            fail_cnt  <= '0;
        end else begin
            pend      <= pend_nxt;
            hit       <= hit_nxt;
            match     <= |mvec;
            fail      <= expire;
            match_cnt <= match_cnt_nxt;
            if (expire && (fail_cnt != '1)) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/delay_seq_matcher.sv
// Multi-channel "a ##[MIN_DELAY:MAX_DELAY] b" hardware monitor with
// registered match/fail pulses and saturating per-channel counters.
module delay_seq_matcher
    import delay_seq_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          MIN_DELAY = 1,
    parameter int          MAX_DELAY = 3,
    parameter match_mode_e MODE      = FIRST_MATCH,
    parameter int          CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [NUM_CH-1:0]       clr_i,
    input  logic [NUM_CH-1:0]       a_i,
    input  logic [NUM_CH-1:0]       b_i,
    output logic [NUM_CH-1:0]       match_o,
    output logic [NUM_CH-1:0]       fail_o,
    output logic [NUM_CH*CNT_W-1:0] match_cnt_o,
    output logic [NUM_CH*CNT_W-1:0] fail_cnt_o
);

    if (MAX_DELAY < 1 || MAX_DELAY > MAX_DELAY_LIMIT) begin : g_bad_max_delay
        $error("delay_seq_matcher: MAX_DELAY must be in 1..63");
    end
    if (MIN_DELAY < 0 || MIN_DELAY > MAX_DELAY) begin : g_bad_min_delay
        $error("delay_seq_matcher: MIN_DELAY must be in 0..MAX_DELAY");
    end
    if (NUM_CH < 1 || NUM_CH > MAX_CH_LIMIT) begin : g_bad_num_ch
        $error("delay_seq_matcher: NUM_CH must be in 1..16");
    end
    if (CNT_W < 2) begin : g_bad_cnt_w
        $error("delay_seq_matcher: CNT_W must be at least 2");
    end

    // en_i only gates attempt creation; pending attempts keep ageing regardless.
    logic [NUM_CH-1:0] a_gated;
    assign a_gated = a_i & {NUM_CH{en_i}};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        delay_seq_channel #(
            .MIN_DELAY (MIN_DELAY),
            .MAX_DELAY (MAX_DELAY),
            .MODE      (MODE),
            .CNT_W     (CNT_W)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr_i[c]),
            .a         (a_gated[c]),
            .b         (b_i[c]),
            .match     (match_o[c]),
            .fail      (fail_o[c]),
            .match_cnt (match_cnt_o[c*CNT_W +: CNT_W]),
            .fail_cnt  (fail_cnt_o[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_delay_seq_matcher.sv
// Self-checking bench: three matcher configurations driven by shared stimulus and
// compared every cycle against an attempt-list reference model.
module tb_delay_seq_matcher;
    import delay_seq_pkg::*;

    localparam int NCH   = 4;
    localparam int ND    = 3;
    localparam int SLOTS = 8;

    localparam int MIN_0 = 1, MAX_0 = 3, CW_0 = 16;
    localparam int MIN_1 = 1, MAX_1 = 3, CW_1 = 16;
    localparam int MIN_2 = 0, MAX_2 = 2, CW_2 = 2;

    localparam int MIN_D [ND] = '{MIN_0, MIN_1, MIN_2};
    localparam int MAX_D [ND] = '{MAX_0, MAX_1, MAX_2};
    localparam int CW_D  [ND] = '{CW_0, CW_1, CW_2};
    localparam bit ALL_D [ND] = '{1'b0, 1'b1, 1'b0};

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [NCH-1:0] clr, a, b;

    logic [NCH-1:0]      mo0, mo1, mo2, fo0, fo1, fo2;
    logic [NCH*CW_0-1:0] mc0, fc0;
    logic [NCH*CW_1-1:0] mc1, fc1;
    logic [NCH*CW_2-1:0] mc2, fc2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: each live attempt is a slot holding its start cycle.
    bit vld  [ND][NCH][SLOTS];
    int st   [ND][NCH][SLOTS];
    bit hitm [ND][NCH][SLOTS];
    bit em   [ND][NCH];
    bit ef   [ND][NCH];
    int emc  [ND][NCH];
    int efc  [ND][NCH];

    always #5 clk = ~clk;

    delay_seq_matcher #(.NUM_CH(NCH), .MIN_DELAY(MIN_0), .MAX_DELAY(MAX_0),
                        .MODE(FIRST_MATCH), .CNT_W(CW_0)) u_dut0 (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .a_i(a), .b_i(b),
        .match_o(mo0), .fail_o(fo0), .match_cnt_o(mc0), .fail_cnt_o(fc0));

    delay_seq_matcher #(.NUM_CH(NCH), .MIN_DELAY(MIN_1), .MAX_DELAY(MAX_1),
                        .MODE(ALL_MATCH), .CNT_W(CW_1)) u_dut1 (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .a_i(a), .b_i(b),
        .match_o(mo1), .fail_o(fo1), .match_cnt_o(mc1), .fail_cnt_o(fc1));

    delay_seq_matcher #(.NUM_CH(NCH), .MIN_DELAY(MIN_2), .MAX_DELAY(MAX_2),
                        .MODE(FIRST_MATCH), .CNT_W(CW_2)) u_dut2 (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .a_i(a), .b_i(b),
        .match_o(mo2), .fail_o(fo2), .match_cnt_o(mc2), .fail_cnt_o(fc2));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int act_match(input int d, input int c);
        logic [NCH-1:0] v;
        case (d)
            0:       v = mo0;
            1:       v = mo1;
            default: v = mo2;
        endcase
        return (v[c] === 1'b1) ? 1 : (v[c] === 1'b0) ? 0 : -1;
    endfunction

    function automatic int act_fail(input int d, input int c);
        logic [NCH-1:0] v;
        case (d)
            0:       v = fo0;
            1:       v = fo1;
            default: v = fo2;
        endcase
        return (v[c] === 1'b1) ? 1 : (v[c] === 1'b0) ? 0 : -1;
    endfunction

    function automatic int act_mcnt(input int d, input int c);
        case (d)
            0:       return int'(mc0[c*CW_0 +: CW_0]);
            1:       return int'(mc1[c*CW_1 +: CW_1]);
            default: return int'(mc2[c*CW_2 +: CW_2]);
        endcase
    endfunction

    function automatic int act_fcnt(input int d, input int c);
        case (d)
            0:       return int'(fc0[c*CW_0 +: CW_0]);
            1:       return int'(fc1[c*CW_1 +: CW_1]);
            default: return int'(fc2[c*CW_2 +: CW_2]);
        endcase
    endfunction

    // Applies one clock edge's worth of the temporal rules to the attempt lists.
    task automatic model_step();
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < NCH; c++) begin
                int  nm;
                bit  f;
                int  lim;
                lim = (1 << CW_D[d]) - 1;
                if (rst || clr[c]) begin
                    for (int s = 0; s < SLOTS; s++) vld[d][c][s] = 1'b0;
                    em[d][c]  = 1'b0;
                    ef[d][c]  = 1'b0;
                    emc[d][c] = 0;
                    efc[d][c] = 0;
                    continue;
                end
                if (a[c] && en) begin
                    for (int s = 0; s < SLOTS; s++) begin
                        if (!vld[d][c][s]) begin
                            vld[d][c][s]  = 1'b1;
                            st[d][c][s]   = cyc;
                            hitm[d][c][s] = 1'b0;
                            break;
                        end
                    end
                end
                nm = 0;
                f  = 1'b0;
                for (int s = 0; s < SLOTS; s++) begin
                    if (vld[d][c][s]) begin
                        int age;
                        bit now;
                        age = cyc - st[d][c][s];
                        now = b[c] && age >= MIN_D[d] && age <= MAX_D[d];
                        if (now) nm++;
                        if (age == MAX_D[d] && !now && !hitm[d][c][s]) f = 1'b1;
                        if (now) hitm[d][c][s] = 1'b1;
                        if ((now && !ALL_D[d]) || age >= MAX_D[d]) vld[d][c][s] = 1'b0;
                    end
                end
                em[d][c]  = (nm > 0);
                ef[d][c]  = f;
                emc[d][c] = (emc[d][c] + nm > lim) ? lim : emc[d][c] + nm;
                if (f && efc[d][c] < lim) efc[d][c] = efc[d][c] + 1;
            end
        end
        cyc++;
    endtask

    task automatic compare_all();
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("match d%0d c%0d cyc%0d", d, c, cyc), act_match(d, c), int'(em[d][c]));
                check($sformatf("fail d%0d c%0d cyc%0d", d, c, cyc), act_fail(d, c), int'(ef[d][c]));
                check($sformatf("mcnt d%0d c%0d cyc%0d", d, c, cyc), act_mcnt(d, c), emc[d][c]);
                check($sformatf("fcnt d%0d c%0d cyc%0d", d, c, cyc), act_fcnt(d, c), efc[d][c]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic [NCH-1:0] av, input logic [NCH-1:0] bv,
                         input logic [NCH-1:0] cv);
        a   = av;
        b   = bv;
        clr = cv;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        clr = '0;
        a   = '0;
        b   = '0;

        // Reset state.
        do_reset();
        check("reset match d0", act_match(0, 0), 0);
        check("reset mcnt d1", act_mcnt(1, 3), 0);

        // Single-shot: a, then b at age 2.
        drive(4'b0001, '0, '0);
        drive('0, '0, '0);
        drive('0, 4'b0001, '0);
        check("single match d0", act_match(0, 0), 1);
        check("single model", int'(em[0][0]), 1);
        check("single mcnt d0", act_mcnt(0, 0), 1);
        idle(4);
        check("single fcnt d0", act_fcnt(0, 0), 0);

        // Expiry: a, no b; fail visible after the age-MAX edge.
        do_reset();
        drive(4'b0001, '0, '0);
        idle(3);
        check("expiry fail d0", act_fail(0, 0), 1);
        check("expiry model", int'(ef[0][0]), 1);
        idle(1);
        check("expiry fcnt d0", act_fcnt(0, 0), 1);
        check("expiry mcnt d0", act_mcnt(0, 0), 0);

        // Overlapping attempts, two b's.
        do_reset();
        drive(4'b0001, '0, '0);
        drive(4'b0001, '0, '0);
        drive('0, 4'b0001, '0);
        check("overlap b1 match d0", act_match(0, 0), 1);
        check("overlap b1 match d1", act_match(1, 0), 1);
        drive('0, 4'b0001, '0);
        check("overlap all mcnt d1", act_mcnt(1, 0), 4);
        check("overlap all model", emc[1][0], 4);
        check("overlap all match d1", act_match(1, 0), 1);
        check("overlap first mcnt d0", act_mcnt(0, 0), 2);
        check("overlap first match d0", act_match(0, 0), 0);
        idle(4);
        check("overlap fcnt d0", act_fcnt(0, 0), 0);
        check("overlap fcnt d1", act_fcnt(1, 0), 0);

        // Zero delay: a and b together.
        do_reset();
        drive(4'b0001, 4'b0001, '0);
        check("zero match d2", act_match(2, 0), 1);
        check("zero mcnt d2", act_mcnt(2, 0), 1);
        check("zero match d0", act_match(0, 0), 0);
        idle(4);

        // Saturation on ch1 of the 2-bit counter, then clear with a simultaneous a.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive((i == 0) ? 4'b0011 : 4'b0010, '0, '0);
            drive('0, (i == 0) ? 4'b0011 : 4'b0010, '0);
        end
        check("sat mcnt d2 c1", act_mcnt(2, 1), 3);
        check("sat model", emc[2][1], 3);
        check("sat mcnt d0 c1", act_mcnt(0, 1), 4);
        check("sat mcnt d2 c0", act_mcnt(2, 0), 1);
        drive(4'b0010, '0, 4'b0010);
        check("clr mcnt d2 c1", act_mcnt(2, 1), 0);
        check("clr mcnt d0 c1", act_mcnt(0, 1), 0);
        check("clr keeps d2 c0", act_mcnt(2, 0), 1);
        check("clr keeps d0 c0", act_mcnt(0, 0), 1);
        idle(5);
        check("clr no attempt d0", act_fcnt(0, 1), 0);

        // Randomised traffic with occasional reset, clear and enable drop.
        for (int i = 0; i < 3000; i++) begin
            logic [NCH-1:0] av, bv, cv;
            for (int c = 0; c < NCH; c++) begin
                av[c] = ($urandom_range(0, 2) == 0);
                bv[c] = ($urandom_range(0, 2) == 0);
                cv[c] = ($urandom_range(0, 63) == 0);
            end
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 9) != 0);
            drive(av, bv, cv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
